// File: rtl/dispatch_credit_queue.sv
`default_nettype none

`ifndef ROB_SZ
`define ROB_SZ 32
`endif
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif

// ============================================================================
// Module   : dispatch_credit_queue
// Purpose  : Registered in-order instruction queue between decode and
//            rename/dispatch, throttled by per-RS-bank credits, ROB space and
//            freelist space. Supports mispredict flush.
// Revision : 1.0 - initial release
// ============================================================================
module dispatch_credit_queue #(
    parameter int WIDTH        = 4,
    parameter int DEPTH        = 16,
    parameter int NUM_BANKS    = 4,
    parameter int BANK_CREDITS = 8,
    parameter int PAYLOAD_BITS = 64,
    localparam int BB = $clog2(NUM_BANKS),
    localparam int CW = $clog2(WIDTH + 1),
    localparam int OW = $clog2(DEPTH + 1),
    localparam int KW = $clog2(BANK_CREDITS + 1),
    localparam int RW = $clog2(`ROB_SZ + 1),
    localparam int FW = $clog2(`PHYS_REG_SZ_R10K + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [CW-1:0]                 in_count,
    input  logic [WIDTH*PAYLOAD_BITS-1:0] in_payload,
    input  logic [WIDTH*BB-1:0]           in_bank,
    input  logic [WIDTH-1:0]              in_uses_rd,
    output logic [OW-1:0]                 free_entries,
    input  logic [RW-1:0]                 rob_free,
    input  logic [FW-1:0]                 freelist_free,
    input  logic [NUM_BANKS*CW-1:0]       credit_return,
    output logic [CW-1:0]                 disp_count,
    output logic [WIDTH*PAYLOAD_BITS-1:0] out_payload,
    output logic [WIDTH*BB-1:0]           out_bank,
    output logic [WIDTH-1:0]              out_uses_rd,
    output logic [NUM_BANKS*KW-1:0]       credits,
    output logic                          err_overflow,
    output logic                          err_credit
);

    localparam int PW = $clog2(DEPTH);

    logic [PAYLOAD_BITS-1:0] r_payload [DEPTH];
    logic [BB-1:0]           r_bank    [DEPTH];
    logic [DEPTH-1:0]        r_rd;
    logic [PW-1:0]           r_head;
    logic [PW-1:0]           r_tail;
    logic [OW-1:0]           r_occ;
    logic [OW-1:0]           r_free;
    logic [KW-1:0]           r_credit  [NUM_BANKS];
    logic                    r_err_overflow;
    logic                    r_err_credit;

    logic [PW-1:0] w_rd_idx [WIDTH];
    logic [PW-1:0] w_wr_idx [WIDTH];
    logic          w_go;
    int            w_disp_n;
    int            w_rd_used;
    int            w_used [NUM_BANKS];
    int            w_in_n;
    int            w_acc;
    logic          w_ovf;
    int            w_cred_sum [NUM_BANKS];
    logic [KW-1:0] w_credit_next [NUM_BANKS];
    logic          w_credit_ovf;
    logic [OW-1:0] w_occ_next;

    // In-order scan from the head: the first lane that fails any limit stops dispatch.
    always_comb begin
        w_go      = !flush;
        w_disp_n  = 0;
        w_rd_used = 0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_used[b] = 0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            w_rd_idx[i] = r_head + PW'(i);
            if (w_go && (i < int'(r_occ)) && (i < int'(rob_free))
                && ((w_rd_used + int'(r_rd[w_rd_idx[i]])) <= int'(freelist_free))
                && (int'(r_credit[r_bank[w_rd_idx[i]]]) > w_used[r_bank[w_rd_idx[i]]])) begin
                w_disp_n  = w_disp_n + 1;
                w_rd_used = w_rd_used + int'(r_rd[w_rd_idx[i]]);
                w_used[r_bank[w_rd_idx[i]]] = w_used[r_bank[w_rd_idx[i]]] + 1;
            end else begin
                w_go = 1'b0;
            end
        end
    end

    always_comb begin
        w_in_n = (int'(in_count) > WIDTH) ? WIDTH : int'(in_count);
        w_ovf  = int'(in_count) > int'(r_free);
        w_acc  = (w_in_n > int'(r_free)) ? int'(r_free) : w_in_n;
        for (int i = 0; i < WIDTH; i++) begin
            w_wr_idx[i] = r_tail + PW'(i);
        end
        w_occ_next = OW'(int'(r_occ) + w_acc - w_disp_n);
    end

    always_comb begin
        w_credit_ovf = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_cred_sum[b] = int'(r_credit[b]) - w_used[b] + int'(credit_return[b*CW +: CW]);
            if (w_cred_sum[b] > BANK_CREDITS) begin
                w_credit_next[b] = KW'(BANK_CREDITS);
                w_credit_ovf     = 1'b1;
            end else begin
                w_credit_next[b] = KW'(w_cred_sum[b]);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && !flush) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i < w_acc) begin
                    r_payload[w_wr_idx[i]] <= in_payload[i*PAYLOAD_BITS +: PAYLOAD_BITS];
                    r_bank[w_wr_idx[i]]    <= in_bank[i*BB +: BB];
                    r_rd[w_wr_idx[i]]      <= in_uses_rd[i];
                end
            end
        end
    end

    // Credits keep absorbing returns during flush: squashed RS entries come back that way.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_occ          <= '0;
            r_free         <= OW'(DEPTH);
            r_err_overflow <= 1'b0;
            r_err_credit   <= 1'b0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_credit[b] <= KW'(BANK_CREDITS);
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_credit[b] <= w_credit_next[b];
            end
            if (w_credit_ovf) begin
                r_err_credit <= 1'b1;
            end
            if (flush) begin
                r_head <= '0;
                r_tail <= '0;
                r_occ  <= '0;
                r_free <= OW'(DEPTH);
            end else begin
                r_head <= r_head + PW'(w_disp_n);
                r_tail <= r_tail + PW'(w_acc);
                r_occ  <= w_occ_next;
                r_free <= OW'(DEPTH) - w_occ_next;
                if (w_ovf) begin
                    r_err_overflow <= 1'b1;
                end
            end
        end
    end

    assign disp_count   = CW'(w_disp_n);
    assign free_entries = r_free;
    assign err_overflow = r_err_overflow;
    assign err_credit   = r_err_credit;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_out_lane
            assign out_payload[i*PAYLOAD_BITS +: PAYLOAD_BITS] =
                (i < w_disp_n) ? r_payload[w_rd_idx[i]] : '0;
            assign out_bank[i*BB +: BB] = (i < w_disp_n) ? r_bank[w_rd_idx[i]] : '0;
            assign out_uses_rd[i]       = (i < w_disp_n) ? r_rd[w_rd_idx[i]] : 1'b0;
        end
        for (genvar b = 0; b < NUM_BANKS; b++) begin : g_credit_out
            assign credits[b*KW +: KW] = r_credit[b];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_dispatch_credit_queue.sv
`default_nettype none
// Testbench for dispatch_credit_queue: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_dispatch_credit_queue;

    localparam int WIDTH = 4;
    localparam int DEPTH = 16;
    localparam int NB    = 4;
    localparam int BC    = 8;
    localparam int PB    = 64;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  flush;
    logic [2:0]            in_count;
    logic [WIDTH*PB-1:0]   in_payload;
    logic [WIDTH*2-1:0]    in_bank;
    logic [WIDTH-1:0]      in_uses_rd;
    logic [4:0]            free_entries;
    logic [5:0]            rob_free;
    logic [6:0]            freelist_free;
    logic [NB*3-1:0]       credit_return;
    logic [2:0]            disp_count;
    logic [WIDTH*PB-1:0]   out_payload;
    logic [WIDTH*2-1:0]    out_bank;
    logic [WIDTH-1:0]      out_uses_rd;
    logic [NB*4-1:0]       credits;
    logic                  err_overflow;
    logic                  err_credit;

    always #5 clock = ~clock;

    dispatch_credit_queue dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .in_count     (in_count),
        .in_payload   (in_payload),
        .in_bank      (in_bank),
        .in_uses_rd   (in_uses_rd),
        .free_entries (free_entries),
        .rob_free     (rob_free),
        .freelist_free(freelist_free),
        .credit_return(credit_return),
        .disp_count   (disp_count),
        .out_payload  (out_payload),
        .out_bank     (out_bank),
        .out_uses_rd  (out_uses_rd),
        .credits      (credits),
        .err_overflow (err_overflow),
        .err_credit   (err_credit)
    );

    // Reference model: an ordered list of queued instructions plus plain counters.
    logic [63:0] q_pay[$];
    int          q_bank[$];
    int          q_rd[$];
    int          m_cred[NB];
    bit          m_eovf;
    bit          m_ecred;
    int          m_free;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic model_reset();
        q_pay.delete();
        q_bank.delete();
        q_rd.delete();
        for (int b = 0; b < NB; b++) m_cred[b] = BC;
        m_eovf  = 0;
        m_ecred = 0;
        m_free  = DEPTH;
    endtask

    function automatic int model_disp();
        int n;
        int rd;
        int used[NB];
        n  = 0;
        rd = 0;
        for (int b = 0; b < NB; b++) used[b] = 0;
        if (flush) return 0;
        for (int i = 0; i < WIDTH && i < q_pay.size(); i++) begin
            if (i >= int'(rob_free)) break;
            if (rd + q_rd[i] > int'(freelist_free)) break;
            if (m_cred[q_bank[i]] - used[q_bank[i]] <= 0) break;
            rd += q_rd[i];
            used[q_bank[i]]++;
            n++;
        end
        return n;
    endfunction

    task automatic set_lane(input int i, input logic [63:0] pay, input int bank, input int rd);
        in_payload[i*PB +: PB] = pay;
        in_bank[i*2 +: 2]      = 2'(bank);
        in_uses_rd[i]          = rd[0];
    endtask

    task automatic tick();
        int d;
        int acc;
        int s;
        int used[NB];
        d = model_disp();
        for (int b = 0; b < NB; b++) used[b] = 0;
        for (int i = 0; i < d; i++) used[q_bank[i]]++;
        @(posedge clock);
        if (reset) begin
            model_reset();
        end else begin
            for (int b = 0; b < NB; b++) begin
                s = m_cred[b] - used[b] + int'(credit_return[b*3 +: 3]);
                if (s > BC) begin
                    s = BC;
                    m_ecred = 1;
                end
                m_cred[b] = s;
            end
            if (flush) begin
                q_pay.delete();
                q_bank.delete();
                q_rd.delete();
            end else begin
                for (int i = 0; i < d; i++) begin
                    void'(q_pay.pop_front());
                    void'(q_bank.pop_front());
                    void'(q_rd.pop_front());
                end
                if (int'(in_count) > m_free) m_eovf = 1;
                acc = (int'(in_count) > WIDTH) ? WIDTH : int'(in_count);
                if (acc > m_free) acc = m_free;
                for (int i = 0; i < acc; i++) begin
                    q_pay.push_back(in_payload[i*PB +: PB]);
                    q_bank.push_back(int'(in_bank[i*2 +: 2]));
                    q_rd.push_back(int'(in_uses_rd[i]));
                end
            end
            m_free = DEPTH - q_pay.size();
        end
        #1;
    endtask

    task automatic do_reset();
        reset         = 1;
        flush         = 0;
        in_count      = 0;
        credit_return = '0;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        in_payload    = '0;
        in_bank       = '0;
        in_uses_rd    = '0;
        rob_free      = 0;
        freelist_free = 0;
        do_reset();
        #2;
        n_cmp++;
        if (free_entries !== 5'd16) begin
            n_fail++;
            $display("FAIL reset_free_entries got %0d want 16", free_entries);
        end
        for (int b = 0; b < NB; b++) begin
            n_cmp++;
            if (credits[b*4 +: 4] !== 4'd8) begin
                n_fail++;
                $display("FAIL reset_credit[%0d] got %0d want 8", b, credits[b*4 +: 4]);
            end
        end
        n_cmp++;
        if (disp_count !== 3'd0 || err_overflow !== 1'b0 || err_credit !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_disp_err got disp=%0d ovf=%b cred=%b want 0/0/0",
                     disp_count, err_overflow, err_credit);
        end
    endtask

    task automatic test_basic_dispatch();
        do_reset();
        rob_free      = 32;
        freelist_free = 32;
        for (int i = 0; i < 4; i++) set_lane(i, 64'h1000 + 64'(i), 0, 1);
        in_count = 4;
        #2;
        n_cmp++;
        if (disp_count !== 3'd0) begin
            n_fail++;
            $display("FAIL basic_enq_cycle_disp got %0d want 0", disp_count);
        end
        tick();
        in_count = 0;
        #2;
        n_cmp++;
        if (disp_count !== 3'd4) begin
            n_fail++;
            $display("FAIL basic_next_cycle_disp got %0d want 4", disp_count);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_payload[i*PB +: PB] !== 64'h1000 + 64'(i)) begin
                n_fail++;
                $display("FAIL basic_payload[%0d] got %h want %h", i,
                         out_payload[i*PB +: PB], 64'h1000 + 64'(i));
            end
        end
        tick();
        #2;
        n_cmp++;
        if (credits[3:0] !== 4'd4) begin
            n_fail++;
            $display("FAIL basic_alu_credit got %0d want 4", credits[3:0]);
        end
    endtask

    task automatic test_in_order_block();
        do_reset();
        rob_free      = 0;
        freelist_free = 32;
        for (int i = 0; i < 4; i++) set_lane(i, 64'(i), 1, 1);
        in_count = 4;
        tick();
        tick();
        in_count = 0;
        rob_free = 32;
        tick();
        tick();
        set_lane(0, 64'hB0, 1, 1);
        set_lane(1, 64'hB1, 0, 1);
        set_lane(2, 64'hB2, 0, 1);
        in_count = 3;
        tick();
        in_count = 0;
        #2;
        n_cmp++;
        if (credits[7:4] !== 4'd0) begin
            n_fail++;
            $display("FAIL block_mult_credit got %0d want 0", credits[7:4]);
        end
        n_cmp++;
        if (disp_count !== 3'd0) begin
            n_fail++;
            $display("FAIL block_in_order got %0d want 0", disp_count);
        end
        credit_return = 12'd1 << 3;
        tick();
        credit_return = '0;
        #2;
        n_cmp++;
        if (disp_count !== 3'd3) begin
            n_fail++;
            $display("FAIL block_after_return got %0d want 3", disp_count);
        end
        tick();
    endtask

    task automatic test_freelist_limit();
        do_reset();
        rob_free      = 32;
        freelist_free = 32;
        for (int i = 0; i < 4; i++) set_lane(i, 64'hC0 + 64'(i), 0, (i % 2 == 0) ? 1 : 0);
        in_count = 4;
        tick();
        in_count      = 0;
        freelist_free = 1;
        #2;
        n_cmp++;
        if (disp_count !== 3'd2) begin
            n_fail++;
            $display("FAIL freelist_limit got %0d want 2", disp_count);
        end
        rob_free      = 1;
        freelist_free = 32;
        #2;
        n_cmp++;
        if (disp_count !== 3'd1) begin
            n_fail++;
            $display("FAIL rob_limit got %0d want 1", disp_count);
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        rob_free      = 0;
        freelist_free = 32;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) set_lane(i, {$urandom, $urandom}, i, 1);
            in_count = (k == 3) ? 2 : 4;
            tick();
        end
        in_count = 0;
        rob_free = 32;
        for (int c = 0; c < 4; c++) tick();
        #2;
        n_cmp++;
        if (free_entries !== 5'd16) begin
            n_fail++;
            $display("FAIL wrap_drained_free got %0d want 16", free_entries);
        end
        for (int i = 0; i < 4; i++) set_lane(i, 64'hA0 + 64'(i), i, 1);
        in_count = 4;
        tick();
        in_count = 0;
        #2;
        n_cmp++;
        if (disp_count !== 3'd4) begin
            n_fail++;
            $display("FAIL wrap_disp got %0d want 4", disp_count);
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (out_payload[i*PB +: PB] !== 64'hA0 + 64'(i)) begin
                n_fail++;
                $display("FAIL wrap_payload[%0d] got %h want %h", i,
                         out_payload[i*PB +: PB], 64'hA0 + 64'(i));
            end
        end
        tick();
        #2;
        n_cmp++;
        if (free_entries !== 5'd16 || disp_count !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_empty got free=%0d disp=%0d want 16/0", free_entries, disp_count);
        end
    endtask

    task automatic test_flush();
        do_reset();
        rob_free      = 32;
        freelist_free = 32;
        for (int i = 0; i < 4; i++) set_lane(i, 64'(i), 0, 1);
        in_count = 4;
        tick();
        in_count = 0;
        tick();
        rob_free = 0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) set_lane(i, {$urandom, $urandom}, int'($urandom_range(0, 3)), 1);
            in_count = (k == 2) ? 2 : 4;
            tick();
        end
        in_count = 0;
        #2;
        n_cmp++;
        if (free_entries !== 5'd6) begin
            n_fail++;
            $display("FAIL flush_pre_free got %0d want 6", free_entries);
        end
        flush         = 1;
        in_count      = 3;
        credit_return = 12'd2;
        rob_free      = 32;
        #2;
        n_cmp++;
        if (disp_count !== 3'd0) begin
            n_fail++;
            $display("FAIL flush_disp_forced got %0d want 0", disp_count);
        end
        tick();
        flush         = 0;
        in_count      = 0;
        credit_return = '0;
        #2;
        n_cmp++;
        if (free_entries !== 5'd16 || disp_count !== 3'd0) begin
            n_fail++;
            $display("FAIL flush_after got free=%0d disp=%0d want 16/0", free_entries, disp_count);
        end
        n_cmp++;
        if (credits[3:0] !== 4'd6) begin
            n_fail++;
            $display("FAIL flush_alu_credit got %0d want 6", credits[3:0]);
        end
        credit_return = 12'd7;
        tick();
        credit_return = '0;
        #2;
        n_cmp++;
        if (credits[3:0] !== 4'd8 || err_credit !== 1'b1) begin
            n_fail++;
            $display("FAIL credit_clamp got credit=%0d err=%b want 8/1", credits[3:0], err_credit);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        rob_free      = 0;
        freelist_free = 32;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 4; i++) set_lane(i, {$urandom, $urandom}, i, 0);
            in_count = 4;
            tick();
        end
        in_count = 0;
        #2;
        n_cmp++;
        if (free_entries !== 5'd0) begin
            n_fail++;
            $display("FAIL full_free got %0d want 0", free_entries);
        end
        rob_free = 32;
        in_count = 4;
        #2;
        n_cmp++;
        if (disp_count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_disp got %0d want 4", disp_count);
        end
        tick();
        in_count = 0;
        #2;
        n_cmp++;
        if (err_overflow !== 1'b1 || free_entries !== 5'd4) begin
            n_fail++;
            $display("FAIL full_overflow got err=%b free=%0d want 1/4", err_overflow, free_entries);
        end
    endtask

    task automatic test_random();
        int n;
        int r;
        int exp;
        do_reset();
        repeat (400) begin
            reset = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 29) == 0);
            n = int'($urandom_range(0, 4));
            if ($urandom_range(0, 9) != 0 && n > m_free) n = m_free;
            in_count = 3'(n);
            for (int i = 0; i < 4; i++)
                set_lane(i, {$urandom, $urandom}, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
            rob_free      = ($urandom_range(0, 3) == 0) ? 6'd32 : 6'($urandom_range(0, 5));
            freelist_free = 7'($urandom_range(0, 5));
            for (int b = 0; b < NB; b++) begin
                r = BC - m_cred[b];
                if (r > 7 || $urandom_range(0, 49) == 0) r = 7;
                credit_return[b*3 +: 3] = 3'($urandom_range(0, r));
            end
            #2;
            exp = model_disp();
            n_cmp++;
            if (int'(disp_count) !== exp) begin
                n_fail++;
                $display("FAIL rand_disp got %0d want %0d", disp_count, exp);
            end
            for (int i = 0; i < exp; i++) begin
                n_cmp++;
                if (out_payload[i*PB +: PB] !== q_pay[i] || int'(out_bank[i*2 +: 2]) !== q_bank[i]
                    || int'(out_uses_rd[i]) !== q_rd[i]) begin
                    n_fail++;
                    $display("FAIL rand_lane[%0d] got %h/%0d/%0d want %h/%0d/%0d", i,
                             out_payload[i*PB +: PB], out_bank[i*2 +: 2], out_uses_rd[i],
                             q_pay[i], q_bank[i], q_rd[i]);
                end
            end
            n_cmp++;
            if (int'(free_entries) !== m_free) begin
                n_fail++;
                $display("FAIL rand_free got %0d want %0d", free_entries, m_free);
            end
            for (int b = 0; b < NB; b++) begin
                n_cmp++;
                if (int'(credits[b*4 +: 4]) !== m_cred[b]) begin
                    n_fail++;
                    $display("FAIL rand_credit[%0d] got %0d want %0d", b, credits[b*4 +: 4], m_cred[b]);
                end
            end
            n_cmp++;
            if (err_overflow !== m_eovf || err_credit !== m_ecred) begin
                n_fail++;
                $display("FAIL rand_err got %b/%b want %b/%b", err_overflow, err_credit, m_eovf, m_ecred);
            end
            tick();
        end
        reset = 0;
        flush = 0;
    endtask

    initial begin
        reset         = 1;
        flush         = 0;
        in_count      = 0;
        credit_return = '0;
        model_reset();
        test_reset();
        test_basic_dispatch();
        test_in_order_block();
        test_freelist_limit();
        test_wrap();
        test_flush();
        test_overflow();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dispatch_credit_queue.md
# dispatch_credit_queue

Parametrised, credit-based instruction buffer between decode and rename/dispatch. It replaces the combinational "count free slots and stop at first hazard" dispatch front end with a registered circular queue. Per-RS-bank credit counters track in-flight allocations, so RS free-slot counts are no longer sampled combinationally. Each cycle the head dispatches in order, up to WIDTH instructions, limited by bank credits, ROB space and freelist space. The queue supports mispredict flush.

## Interface
- WIDTH, 4: instructions enqueued/dispatched per cycle.
- DEPTH, 16: queue entries; power of 2, must be ≥ WIDTH.
- NUM_BANKS, 4: RS banks (ALU, MULT, BRANCH, MEM order).
- BANK_CREDITS, 8: initial and maximum credits per bank.
- PAYLOAD_BITS, 64: opaque per-instruction payload width.
- Derived: BB = $clog2(NUM_BANKS), CW = $clog2(WIDTH+1), OW = $clog2(DEPTH+1), KW = $clog2(BANK_CREDITS+1).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  mispredict squash of all queued instructions.
- in_count  in  CW  number of valid enqueue lanes; lanes 0..in_count-1 are valid.
- in_payload  in  WIDTH×PAYLOAD_BITS  instruction payloads.
- in_bank  in  WIDTH×BB  target RS bank per lane.
- in_uses_rd  in  WIDTH  lane needs a physical destination register.
- free_entries  out  OW  registered free-slot count; upstream must not send more than this.
- rob_free  in  $clog2(`ROB_SZ+1)  ROB free slots this cycle.
- freelist_free  in  $clog2(`PHYS_REG_SZ_R10K+1)  free physical registers this cycle.
- credit_return  in  NUM_BANKS×CW  RS entries freed per bank this cycle (issue or squash).
- disp_count  out  CW  instructions dispatched this cycle, taken from the head.
- out_payload / out_bank / out_uses_rd  out  WIDTH×…  head entries; lanes below disp_count are valid.
- credits  out  NUM_BANKS×KW  current credit counters.
- err_overflow  out  1  sticky: an enqueue exceeded free_entries.
- err_credit  out  1  sticky: a credit return would exceed BANK_CREDITS.

## Operation
- Storage: DEPTH-entry circular buffer with head/tail pointers ($clog2(DEPTH) bits, wrap modulo DEPTH) and an OW-bit occupancy counter. Full and empty are decided by occupancy only.
- Dispatch scan runs over lanes i = 0..min(occ,WIDTH)-1 starting at the head. Lane i dispatches only if every earlier lane dispatched and all of the following hold:
  - i < rob_free;
  - the number of uses_rd lanes dispatched so far plus this lane's own uses_rd is ≤ freelist_free;
  - the credit for its bank, minus the lanes already dispatched to that bank this cycle, is > 0.
- Dispatch stops at the first lane that fails; there is no bypassing. disp_count is the number of lanes dispatched. Downstream (ROB, RS, freelist, map table) must accept every lane below disp_count in the same cycle.
- Enqueue: lanes 0..in_count-1 are written at tail..tail+in_count-1, wrapping.
  - If in_count > free_entries, only free_entries lanes are written and err_overflow is set.
- Occupancy update: occ_next = occ + accepted − disp_count.
- Credits: credit_next[b] = credit[b] − dispatched_to_b + credit_return[b].
  - If the result exceeds BANK_CREDITS, clamp it to BANK_CREDITS and set err_credit.
  - Credits never underflow, because the scan enforces credit > 0.
- Flush: head, tail and occupancy go to 0 and disp_count is forced to 0 that cycle. In-cycle enqueue is dropped. Credits still take credit_return, because the RS returns squashed entries through that port. Flush has priority over enqueue and dispatch.
- Reset values: queue empty, free_entries = DEPTH, disp_count = 0, outputs zero, all credits = BANK_CREDITS, both error flags 0. Reset has priority over flush.

## Timing
- Enqueue-to-dispatch latency is 1 cycle minimum. Entries written at edge k are eligible for dispatch in cycle k+1; there is no same-cycle bypass.
- disp_count and out_* are combinational from registered queue state plus rob_free, freelist_free and credits. They contain no combinational path from in_*.
- free_entries is registered and reflects occupancy after edge k. Upstream uses it in cycle k+1 without seeing that cycle's dispatch. This is conservative but safe.
- A credit returned in cycle k is usable by the dispatch scan in cycle k+1.
- Simultaneous enqueue and dispatch at full occupancy: free_entries = 0, so the enqueue is rejected (err_overflow if attempted) even though dispatch frees slots that cycle.
- Pointer wrap: with DEPTH = 16 and tail = 14, enqueueing 4 lanes writes entries 14, 15, 0, 1, and tail becomes 2.
- Reset asserted mid-operation takes effect at the next edge and discards all queued entries and credit state.

## Test plan
- Reset → free_entries = 16, credits = {8,8,8,8}, disp_count = 0, both error flags 0.
- Enqueue 4 ALU ops with in_uses_rd = 1, rob_free = 32, freelist_free = 32 → disp_count = 0 on the enqueue cycle, 4 the next cycle; ALU credit becomes 4.
- Head bank sequence MULT, ALU, ALU with MULT credit 0 → disp_count = 0 (in-order block). Then credit_return[MULT] = 1 → next cycle disp_count = 3.
- freelist_free = 1, head lanes uses_rd = {1,0,1,0} → disp_count = 2. rob_free = 1 → disp_count = 1.
- tail = 14, enqueue 4, then dispatch 4 per cycle → payloads emerge in order across the wrap; occupancy returns to 0.
- Flush with 10 entries queued plus in_count = 3 and credit_return[ALU] = 2 → next cycle occupancy = 0, free_entries = 16, ALU credit +2. Also: credit_return taking ALU above 8 → clamped to 8, err_credit = 1.
